mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch requester and the data-memory (M stage) requester of the 5-stage pipeline. Arbitrates between pending requests and issues exactly one memory access at a time. Sequences the fixed-latency memory access with a state machine. Returns read data and a one-cycle ready pulse to the granted requester; the pipeline stalls the requesting stage until that pulse arrives.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MEM_LATENCY, 2, cycles from the mem_en_o cycle to valid mem_rdata_i (legal range 1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request; held high until if_ready_o
if_addr_i  in  ADDR_WIDTH  fetch address; stable while if_req_i is high
if_rdata_o  out  DATA_WIDTH  fetch read data; valid while if_ready_o is high, then held
if_ready_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request; held high until d_ready_o
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  write data
d_rdata_o  out  DATA_WIDTH  data read data; valid while d_ready_o is high, then held
d_ready_o  out  1  one-cycle completion pulse for data
mem_en_o  out  1  memory access strobe, one cycle per access
mem_we_o  out  1  memory write enable, qualified by mem_en_o
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the mem_en_o cycle
busy_o  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: single clock clk_i; synchronous active-high reset on rst_i.
- Reset values: state IDLE; grant NONE; counter 0.
- Reset values of outputs: if_rdata_o=0, d_rdata_o=0, every ready output 0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0.
- States:
  - IDLE: samples if_req_i and d_req_i. If neither is high, stays in IDLE. If either is high, picks a grant, latches the granted port's addr, we and wdata into mem_* registers, and goes to ISSUE.
  - ISSUE: mem_en_o=1 for exactly one cycle. mem_we_o = latched we, and is 1 only for a data write. Loads counter with MEM_LATENCY-1 and goes to WAIT.
  - WAIT: counter decrements each cycle. When counter==0, captures mem_rdata_i into the granted port's rdata register (reads only) and goes to RESP.
  - RESP: the granted port's ready output is 1 for one cycle. Goes to IDLE and clears the grant.
- Writes:
  - Follow the same ISSUE/WAIT/RESP timing as reads.
  - d_rdata_o keeps its previous value.
- Latency:
  - Request first seen in IDLE at cycle t: mem_en_o at t+1, ready at t+2+MEM_LATENCY.
  - One access per MEM_LATENCY+3 cycles at best, including the IDLE sampling cycle.
- Request sampling:
  - Requests are sampled only in IDLE. Changes on req, addr or data during ISSUE, WAIT or RESP are ignored.
  - A requester that drops req before it is granted is never served.
  - A req still high in the IDLE cycle after RESP is a new request.
- Default priority: when both requests are high in IDLE, data wins, because it belongs to the older instruction. Fetch can starve while d_req_i stays high.
- mem_* outputs:
  - Registered; no combinational path from any req/addr input to mem_*.
  - mem_addr_o and mem_wdata_o hold their latched values through WAIT and RESP.
  - mem_en_o and mem_we_o are 0 outside ISSUE.
- Ready outputs: never both high in the same cycle; never high outside RESP.
- Reset in the middle of an access: returns to IDLE next cycle with no ready pulse. The in-flight access is abandoned; a write already strobed is not undone.
- Counter: width 4, enough for MEM_LATENCY<=15. MEM_LATENCY=1 gives one WAIT cycle.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin priority. A 1-bit last_gnt register (reset: FETCH) records the last port served. On a conflict in IDLE, the port not in last_gnt wins. last_gnt updates on entering ISSUE. A single request is always granted.
- Undefined: fixed data-first priority; no last_gnt register.

Decomposition:
- Package mem_arb_pkg:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - grant enum: GNT_NONE, GNT_IF, GNT_D
  - localparam CNT_W = 4
- One combinational sub-module, arb_prio:
  - Inputs: if_req, d_req, last_gnt.
  - Output: grant.
  - Contains the MEM_ARB_RR_EN selection, so the FSM is identical in both builds.

Test Plan:
1. MEM_LATENCY=2; fetch-only request at cycle 0, if_addr_i=0x10; memory returns 0xDEADBEEF -> mem_en_o=1, mem_we_o=0, mem_addr_o=0x10 at cycle 1; if_ready_o=1 with if_rdata_o=0xDEADBEEF at cycle 4; d_ready_o stays 0.
2. Data write at cycle 0, d_addr_i=0x20, d_wdata_i=0x1234 -> mem_en_o=1, mem_we_o=1, mem_wdata_o=0x1234 at cycle 1; d_ready_o at cycle 4; d_rdata_o unchanged.
3. Both requests high at cycle 0, released on their own ready pulses (data read returns 0xA5A5A5A5, fetch read returns 0x00500093) -> data served first: d_ready_o at cycle 4 with d_rdata_o=0xA5A5A5A5; fetch mem_en_o at cycle 6; if_ready_o at cycle 9 with if_rdata_o=0x00500093.
4. Both requests held continuously for 4 accesses -> without MEM_ARB_RR_EN: ready order D,D,D,D. With MEM_ARB_RR_EN: order D,F,D,F.
5. rst_i=1 during cycle 2 (WAIT) of a fetch read -> cycle 3: state IDLE, every output at its reset value, no if_ready_o pulse; a new request at cycle 3 completes at cycle 7.
6. MEM_LATENCY=1; fetch-only request at cycle 0 -> mem_en_o at cycle 1; mem_rdata_i captured at cycle 2; if_ready_o at cycle 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding, counter width.
// Build option MEM_ARB_RR_EN (round-robin priority) is consumed by arb_prio and mem_arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } grant_t;

    // Encoding of the 1-bit last-served register used by round-robin priority.
    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_D  = 1'b1;

endpackage

// File: rtl/arb_prio.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_RR_EN defined: round-robin on conflict; undefined: data always wins.
module arb_prio
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   last_gnt,
    output grant_t grant
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
        grant = GNT_NONE;
        if (if_req && d_req) begin
            grant = (last_gnt == LAST_IF) ? GNT_D : GNT_IF;
        end else if (d_req) begin
            grant = GNT_D;
        end else if (if_req) begin
            grant = GNT_IF;
        end
    end
`else
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = last_gnt;

    always_comb begin
        // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
        grant = GNT_NONE;
        if (d_req) begin
            grant = GNT_D;
        end else if (if_req) begin
            grant = GNT_IF;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one fixed-latency single-port memory.
// Optional macro MEM_ARB_RR_EN selects round-robin instead of data-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ready_o,

    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ready_o,

    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,

    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

    state_t                r_state;
    grant_t                r_grant;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_ready;
    logic                  r_d_ready;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;

    grant_t                w_grant;
    logic                  w_last_gnt;

`ifdef MEM_ARB_RR_EN
    logic                  r_last_gnt;
    assign w_last_gnt = r_last_gnt;
`else
    assign w_last_gnt = LAST_IF;
`endif

    arb_prio u_arb_prio (
        .if_req   (if_req_i),
        .d_req    (d_req_i),
        .last_gnt (w_last_gnt),
        .grant    (w_grant)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_state     <= IDLE;
            r_grant     <= GNT_NONE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_gnt  <= LAST_IF;
`endif
        end else begin
            // Strobes and ready pulses are single-cycle unless a state sets them below.
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant != GNT_NONE) begin
                        r_grant  <= w_grant;
                        r_state  <= ISSUE;
                        r_busy   <= 1'b1;
                        r_mem_en <= 1'b1;
                        if (w_grant == GNT_D) begin
                            r_mem_addr  <= d_addr_i;
                            r_mem_wdata <= d_wdata_i;
                            r_we        <= d_we_i;
                            r_mem_we    <= d_we_i;
                        end else begin
                            r_mem_addr  <= if_addr_i;
                            r_mem_wdata <= '0;
                            r_we        <= 1'b0;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last_gnt <= (w_grant == GNT_D) ? LAST_D : LAST_IF;
`endif
                    end
                end

                ISSUE: begin
                    r_cnt   <= LAT_M1;
                    r_state <= WAIT;
                end

                WAIT: begin
                    if (r_cnt == '0) begin
                        // Writes leave the requester's read-data register untouched.
                        if (!r_we) begin
                            if (r_grant == GNT_IF) begin
                                r_if_rdata <= mem_rdata_i;
                            end else begin
                                r_d_rdata <= mem_rdata_i;
                            end
                        end
                        r_if_ready <= (r_grant == GNT_IF);
                        r_d_ready  <= (r_grant == GNT_D);
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o  = r_if_rdata;
    assign if_ready_o  = r_if_ready;
    assign d_rdata_o   = r_d_rdata;
    assign d_ready_o   = r_d_ready;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory accesses and
// responses; a negedge monitor pops and compares whenever the DUT strobes or pulses ready.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: MEM_LATENCY = 2
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, busy;
    logic [31:0] mem_rdata = 32'h0;

    // Instance 1: MEM_LATENCY = 1
    logic        if_req_1, d_req_1, d_we_1;
    logic [31:0] if_addr_1, d_addr_1, d_wdata_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
    logic        if_ready_1, d_ready_1, mem_en_1, mem_we_1, busy_1;
    logic [31:0] mem_rdata_1;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_ready_o(d_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_1), .if_addr_i(if_addr_1), .if_rdata_o(if_rdata_1), .if_ready_o(if_ready_1),
        .d_req_i(d_req_1), .d_we_i(d_we_1), .d_addr_i(d_addr_1), .d_wdata_i(d_wdata_1),
        .d_rdata_o(d_rdata_1), .d_ready_o(d_ready_1),
        .mem_en_o(mem_en_1), .mem_we_o(mem_we_1), .mem_addr_o(mem_addr_1), .mem_wdata_o(mem_wdata_1),
        .mem_rdata_i(mem_rdata_1), .busy_o(busy_1)
    );

    typedef struct {
        int          inst;
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          inst;
        int          cyc;
        bit          is_d;
        logic [31:0] data;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model for instance 0: writes update the array, reads return data
    // exactly two cycles after the strobe cycle and garbage at every other time.
    logic [31:0] mem_model [logic [31:0]];
    bit          pend = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_data = 32'h0;

    always @(negedge clk) begin
        if (mem_en && !rst_i) begin
            if (mem_we) begin
                mem_model[mem_addr] = mem_wdata;
            end else begin
                pend      = 1'b1;
                pend_due  = cyc + 2;
                pend_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
            end
        end
        mem_rdata = (pend && cyc == pend_due) ? pend_data : (32'hBAD0_0000 ^ cyc);
    end

    task automatic mon_mem(input int inst, input logic en, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        mem_exp_t e;
        if (!en) begin
            check($sformatf("mem_we_outside_issue%0d", inst), we, 1'b0);
            return;
        end
        if (exp_mem.size() == 0) begin
            check($sformatf("mem_en_unexpected%0d", inst), en, 1'b0);
            return;
        end
        e = exp_mem.pop_front();
        check("mem_inst", inst, e.inst);
        check("mem_cycle", cyc, e.cyc);
        check("mem_we", we, e.we);
        check("mem_addr", addr, e.addr);
        if (e.we) check("mem_wdata", wdata, e.wdata);
    endtask

    task automatic mon_rsp(input int inst, input bit is_d, input logic rdy, input logic [31:0] data);
        rsp_exp_t e;
        if (!rdy) return;
        if (exp_rsp.size() == 0) begin
            check($sformatf("ready_unexpected%0d_%0d", inst, is_d), rdy, 1'b0);
            return;
        end
        e = exp_rsp.pop_front();
        check("rsp_inst", inst, e.inst);
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_port_is_d", is_d, e.is_d);
        check("rsp_data", data, e.data);
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            check("ready_exclusive0", if_ready & d_ready, 1'b0);
            check("ready_exclusive1", if_ready_1 & d_ready_1, 1'b0);
            mon_mem(0, mem_en, mem_we, mem_addr, mem_wdata);
            mon_mem(1, mem_en_1, mem_we_1, mem_addr_1, mem_wdata_1);
            mon_rsp(0, 1'b0, if_ready, if_rdata);
            mon_rsp(0, 1'b1, d_ready, d_rdata);
            mon_rsp(1, 1'b0, if_ready_1, if_rdata_1);
            mon_rsp(1, 1'b1, d_ready_1, d_rdata_1);
        end
    end

    bit saw_if0, saw_d0, saw_busy0, saw_if1;

    // Samples at the negedge, then returns 1 time unit after the next posedge.
    task automatic step();
        @(negedge clk);
        saw_if0   = if_ready;
        saw_d0    = d_ready;
        saw_busy0 = busy;
        saw_if1   = if_ready_1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit want_if, input bit want_d, input int budget, input string name);
        bit got_if;
        bit got_d;
        int n;
        got_if = !want_if;
        got_d  = !want_d;
        n      = 0;
        while (!(got_if && got_d) && n < budget) begin
            step();
            n++;
            if (saw_if0) begin if_req = 1'b0; got_if = 1'b1; end
            if (saw_d0)  begin d_req  = 1'b0; got_d  = 1'b1; end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check({name, "_completed"}, {got_if, got_d}, 2'b11);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_if_rdata"}, if_rdata, 32'h0);
        check({tag, "_d_rdata"}, d_rdata, 32'h0);
        check({tag, "_strobes"}, {if_ready, d_ready, mem_en, mem_we, busy}, 5'b0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    int  t0;
    int  n_rdy;
    bit  got;
    bit  exp_d;

    initial begin
        rst_i = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req_1 = 0; if_addr_1 = 0; d_req_1 = 0; d_we_1 = 0; d_addr_1 = 0; d_wdata_1 = 0;
        mem_rdata_1 = 32'hBAD1_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        check("reset_busy_l1", busy_1, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // 1: fetch-only read, busy profile across the access
        mem_model[32'h10] = 32'hDEADBEEF;
        t0 = cyc;
        if_addr = 32'h10;
        if_req  = 1'b1;
        exp_mem.push_back('{0, t0 + 1, 1'b0, 32'h10, 32'h0});
        exp_rsp.push_back('{0, t0 + 4, 1'b0, 32'hDEADBEEF});
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t1_busy_k%0d", k), saw_busy0, (k >= 1 && k <= 4));
            if (saw_if0) if_req = 1'b0;
        end
        if_req = 1'b0;

        // 2: data write, d_rdata keeps its reset value
        t0 = cyc;
        d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234; d_req = 1'b1;
        exp_mem.push_back('{0, t0 + 1, 1'b1, 32'h20, 32'h1234});
        exp_rsp.push_back('{0, t0 + 4, 1'b1, 32'h0});
        wait_done(1'b0, 1'b1, 12, "t2");
        d_we = 1'b0;

        // 3: simultaneous requests from reset, data first
        do_reset();
        mem_model[32'h24] = 32'hA5A5A5A5;
        mem_model[32'h28] = 32'h00500093;
        t0 = cyc;
        d_addr = 32'h24; if_addr = 32'h28; d_req = 1'b1; if_req = 1'b1;
        exp_mem.push_back('{0, t0 + 1, 1'b0, 32'h24, 32'h0});
        exp_rsp.push_back('{0, t0 + 4, 1'b1, 32'hA5A5A5A5});
        exp_mem.push_back('{0, t0 + 6, 1'b0, 32'h28, 32'h0});
        exp_rsp.push_back('{0, t0 + 9, 1'b0, 32'h00500093});
        wait_done(1'b1, 1'b1, 20, "t3");

        // 4: both requests held for four accesses
        mem_model[32'h30] = 32'h11112222;
        mem_model[32'h34] = 32'h33334444;
        t0 = cyc;
        d_addr = 32'h30; if_addr = 32'h34; d_req = 1'b1; if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            exp_mem.push_back('{0, t0 + 1 + 5 * k, 1'b0, exp_d ? 32'h30 : 32'h34, 32'h0});
            exp_rsp.push_back('{0, t0 + 4 + 5 * k, exp_d, exp_d ? 32'h11112222 : 32'h33334444});
        end
        n_rdy = 0;
        for (int n = 0; n < 30 && n_rdy < 4; n++) begin
            step();
            if (saw_if0 || saw_d0) n_rdy++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("t4_ready_count", n_rdy, 4);

        // 2b: write after a data read leaves d_rdata at the last read value
        t0 = cyc;
        d_we = 1'b1; d_addr = 32'h38; d_wdata = 32'h0000FEED; d_req = 1'b1;
        exp_mem.push_back('{0, t0 + 1, 1'b1, 32'h38, 32'h0000FEED});
        exp_rsp.push_back('{0, t0 + 4, 1'b1, 32'h11112222});
        wait_done(1'b0, 1'b1, 12, "t2b");
        d_we = 1'b0;

        // 5: reset during WAIT abandons the access; the held request restarts
        mem_model[32'h40] = 32'hCAFEF00D;
        t0 = cyc;
        if_addr = 32'h40; if_req = 1'b1;
        exp_mem.push_back('{0, t0 + 1, 1'b0, 32'h40, 32'h0});
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_mem.push_back('{0, t0 + 4, 1'b0, 32'h40, 32'h0});
        exp_rsp.push_back('{0, t0 + 7, 1'b0, 32'hCAFEF00D});
        @(negedge clk);
        check_reset("t5_after_reset");
        wait_done(1'b1, 1'b0, 12, "t5");

        // 6: MEM_LATENCY = 1 instance, data valid only in the cycle after the strobe
        t0 = cyc;
        if_addr_1 = 32'h50; if_req_1 = 1'b1;
        exp_mem.push_back('{1, t0 + 1, 1'b0, 32'h50, 32'h0});
        exp_rsp.push_back('{1, t0 + 3, 1'b0, 32'h13579BDF});
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            mem_rdata_1 = (cyc == t0 + 2) ? 32'h13579BDF : (32'hBAD1_0000 ^ cyc);
            step();
            if (saw_if1) begin if_req_1 = 1'b0; got = 1'b1; end
        end
        if_req_1 = 1'b0;
        check("t6_completed", got, 1'b1);

        repeat (3) step();
        check("exp_mem_drained", exp_mem.size(), 0);
        check("exp_rsp_drained", exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
